conv_layer_stream: RTL and testbench
====================================

// Module: conv_layer_stream
// PURPOSE
//  Time-multiplexed, parametrised successor to the fully parallel conv layer.
//  Computes a D-deep, FxF convolution over an HxW image for C output channels, with stride S and zero padding P.
//  C MAC lanes run in parallel, one tap per cycle. Results stream out one output position at a time over valid/ready.
//  Sits between the image/filter bus registers and the pooling/activation stage.
// PARAMETERS
//  DATA_WIDTH 32  signed two's-complement fixed-point word width
//  FRAC       0   fraction bits of data/filter; result = acc >>> FRAC
//  D          1   input depth
//  H          32  image height
//  W          32  image width
//  F          5   filter size (FxF)
//  C          4   output channels = MAC lanes
//  S          1   stride (>=1)
//  P          0   zero padding per side (0..F-1)
//  derived: OH=(H+2P-F)/S+1, OW=(W+2P-F)/S+1, T=D*F*F, ACC_W=2*DATA_WIDTH+$clog2(T)
// PORTS
//  clk       in   1               rising-edge clock
//  reset     in   1               synchronous, active-high
//  start     in   1               begin a layer pass; ignored while busy
//  image     in   D*H*W*DATA_WIDTH   word (k,r,c) at [(k*H*W+r*W+c)*DATA_WIDTH +: DATA_WIDTH]; [0:N-1] order
//  filter    in   C*T*DATA_WIDTH  word (ch,k,i,j) at [(ch*T+k*F*F+i*F+j)*DATA_WIDTH +: DATA_WIDTH]
//  out_data  out  C*DATA_WIDTH    channel ch at [ch*DATA_WIDTH +: DATA_WIDTH]
//  out_valid out  1               out_data holds one output position
//  out_ready in   1               consumer accepts when out_valid&&out_ready
//  out_last  out  1               qualifies out_valid: final position (OH-1,OW-1)
//  busy      out  1               high from the cycle after start accepted until done
//  done      out  1               one-cycle pulse after the last beat is accepted
// BEHAVIOUR
//  Reset: state IDLE; out_valid, out_last, busy, done = 0; out_data, accumulators, counters = 0.
//  image/filter are not sampled; they must be held stable while busy (caller's obligation).
//  FSM: IDLE -start-> RUN; RUN (T cycles, tap counter t=0..T-1) -> FLUSH (2 cycles) -> OUT;
//   OUT -out_valid&&out_ready, not last-> RUN, next position;
//   OUT -accepted, last-> IDLE with done=1 for that one cycle.
//  Tap order within a position: k outer, then i, then j (t = k*F*F+i*F+j).
//  Position order: row-major (oy outer, ox inner), from (0,0).
//  Pipeline: tap t is fetched in RUN cycle t; product registered at t+1; accumulated at t+2.
//   out_valid rises exactly T+2 cycles after the first RUN cycle of a position.
//   Accumulators clear at the first tap of each position.
//  Pixel fetch: row = oy*S+i-P, col = ox*S+j-P. If out of [0,H-1] x [0,W-1], pixel = 0 (padding).
//  Arithmetic: DATA_WIDTH x DATA_WIDTH full-precision product; sum in ACC_W bits (no overflow).
//   Result = acc >>> FRAC (arithmetic shift, truncate toward -inf).
//   Result saturates to [-2^(DW-1), 2^(DW-1)-1].
//  Handshake: out_data, out_last stable while out_valid && !out_ready. No compute overlaps OUT.
//   out_valid drops the cycle after acceptance.
//  start while busy: ignored. start in the same cycle as a done pulse: ignored (FSM still leaving OUT).
//  reset mid-pass: back to IDLE next edge; in-flight position discarded; no done pulse.
//  Throughput: one position per (T+3) cycles with out_ready held high.
// STRUCTURE
//  Shared package conv_pkg: sat/trunc function, $clog2 derived-width constants, FSM state encodings.
//  Sub-module conv_mac_lane (x C): registered multiply, ACC_W accumulate, clear, shift+saturate output.
//  Top level holds the FSM, the oy/ox/t counters, the address/padding mux, and the output register.
// TESTING
//  1 D=1,H=W=4,F=3,S=1,P=0,C=2,FRAC=0; image 1..16 row-major; ch0 filter all 1, ch1 center-only 1
//    -> beats ch0={54,63,90,99}, ch1={6,7,10,11}; out_last on beat 4; then done pulse.
//  2 Same image, S=2,P=1, ch0 all-ones -> OH=OW=2; beat0 ch0=14, beat1 ch0=30; out-of-range taps contribute 0.
//  3 Test 1 with out_ready low 5 cycles at beat 2 -> out_data/out_last held; no beat lost or duplicated;
//    each out_valid rise is exactly T+2=11 cycles after its first RUN cycle.
//  4 DATA_WIDTH=16, FRAC=0; image all 30000, filter all 1 -> every output 32767;
//    image all -30000 -> -32768 (saturation).
//  5 Assert reset during beat 2 compute -> next cycle busy=0, out_valid=0, no done;
//    a fresh start then reproduces test 1 exactly.
//  6 Pulse start while busy and in the done cycle -> ignored; beat count stays OH*OW; exactly one done per pass.

Source files
------------

// File: rtl/conv_layer_stream_pkg.sv
// Shared definitions for the streaming convolution layer.
//   conv_state_e  : layer FSM state encodings
//   cw()          : counter width for a range of n values (at least 1 bit)
//   acc_width()   : accumulator width that cannot overflow for t taps
//   sat_trunc()   : arithmetic right shift by frac, then saturate to dw bits
package conv_layer_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_OUT   = 2'd3
    } conv_state_e;

    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int acc_width(input int dw, input int t);
        return 2 * dw + $clog2(t);
    endfunction

    // Works on a 128-bit sign-extended accumulator so one helper serves
    // every lane width; callers truncate the 64-bit result to dw bits.
    function automatic logic signed [63:0] sat_trunc(input logic signed [127:0] acc,
                                                     input int dw, input int frac);
        logic signed [127:0] sh;
        logic signed [127:0] hi;
        logic signed [127:0] lo;
        sh = acc >>> frac;
        hi = (128'sd1 <<< (dw - 1)) - 128'sd1;
        lo = -(128'sd1 <<< (dw - 1));
        if (sh > hi) begin
            return hi[63:0];
        end else if (sh < lo) begin
            return lo[63:0];
        end else begin
            return sh[63:0];
        end
    endfunction

endpackage

// File: rtl/conv_layer_stream_if.sv
// Output stream of the convolution layer: one output position (all C
// channels) per beat, valid/ready handshake, last marks position (OH-1,OW-1).
//   master : producer (conv_layer_stream)
//   slave  : consumer (pooling/activation stage)
interface conv_layer_stream_if #(
    parameter int DATA_WIDTH = 32,
    parameter int C          = 4
);
    logic [C*DATA_WIDTH-1:0] out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_last;

    modport master (output out_data, output out_valid, output out_last, input out_ready);
    modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/conv_layer_stream_mac_lane.sv
// One output-channel MAC lane: registered product, ACC_W accumulation,
// restart on the first tap of a position, shift+saturate result.
//   pix_i/wgt_i   : operands of the tap fetched this cycle
//   tap_vld_i     : a tap is being fetched this cycle
//   tap_first_i   : that tap is the first of a position
//   res_o         : saturated, shifted accumulator (valid two cycles after the last tap)
module conv_mac_lane
    import conv_layer_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC       = 0,
    parameter int ACC_W      = 69
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic signed [DATA_WIDTH-1:0] pix_i,
    input  logic signed [DATA_WIDTH-1:0] wgt_i,
    input  logic                         tap_vld_i,
    input  logic                         tap_first_i,
    output logic signed [DATA_WIDTH-1:0] res_o
);
    localparam int PW = 2 * DATA_WIDTH;

    logic signed [PW-1:0]    prod_q;
    logic                    vld_q;
    logic                    first_q;
    logic signed [ACC_W-1:0] acc_q;

    // Product stage then accumulate stage; the first tap overwrites instead of adding.
    always_ff @(posedge clk) begin
        if (reset) begin
            prod_q  <= {PW{1'b0}};
            vld_q   <= 1'b0;
            first_q <= 1'b0;
            acc_q   <= {ACC_W{1'b0}};
        end else begin
            prod_q  <= PW'(pix_i) * PW'(wgt_i);
            vld_q   <= tap_vld_i;
            first_q <= tap_vld_i & tap_first_i;
            if (vld_q) begin
                if (first_q) begin
                    acc_q <= ACC_W'(prod_q);
                end else begin
                    acc_q <= acc_q + ACC_W'(prod_q);
                end
            end
        end
    end

    assign res_o = DATA_WIDTH'(sat_trunc(128'(acc_q), DATA_WIDTH, FRAC));

endmodule

// File: rtl/conv_layer_stream.sv
// Time-multiplexed D x F x F convolution over an H x W image, C channels in
// parallel (one tap per cycle), stride S, zero padding P. Positions stream out
// row-major over out_if.
//   clk, reset (sync, active-high)
//   start_i   : begin a pass (ignored while busy and in the done cycle)
//   image_i   : word (k,r,c) at [(k*H*W+r*W+c)*DATA_WIDTH +: DATA_WIDTH], held while busy
//   filter_i  : word (ch,k,i,j) at [(ch*T+k*F*F+i*F+j)*DATA_WIDTH +: DATA_WIDTH]
//   busy_o    : pass in progress
//   done_o    : one-cycle pulse after the last beat is accepted
//   out_if    : result stream (master)
module conv_layer_stream
    import conv_layer_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC       = 0,
    parameter int D          = 1,
    parameter int H          = 32,
    parameter int W          = 32,
    parameter int F          = 5,
    parameter int C          = 4,
    parameter int S          = 1,
    parameter int P          = 0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start_i,
    input  logic [D*H*W*DATA_WIDTH-1:0]     image_i,
    input  logic [C*D*F*F*DATA_WIDTH-1:0]   filter_i,
    output logic                            busy_o,
    output logic                            done_o,
    conv_layer_stream_if.master             out_if
);
    localparam int OH    = (H + 2 * P - F) / S + 1;
    localparam int OW    = (W + 2 * P - F) / S + 1;
    localparam int T     = D * F * F;
    localparam int ACC_W = acc_width(DATA_WIDTH, T);
    localparam int NPIX  = D * H * W;
    localparam int TW    = cw(T);
    localparam int FW    = cw(F);
    localparam int KW    = cw(D);
    localparam int YW    = cw(OH);
    localparam int XW    = cw(OW);
    localparam int IW    = cw(NPIX);

    conv_state_e             state_q;
    logic [TW-1:0]           t_q;
    logic [KW-1:0]           k_q;
    logic [FW-1:0]           i_q;
    logic [FW-1:0]           j_q;
    logic [YW-1:0]           oy_q;
    logic [XW-1:0]           ox_q;
    logic                    flush_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    out_valid_q;
    logic                    out_last_q;
    logic [C*DATA_WIDTH-1:0] out_data_q;

    logic signed [DATA_WIDTH-1:0] img_s [NPIX];
    logic signed [DATA_WIDTH-1:0] wgt_s [C][T];
    logic [C*DATA_WIDTH-1:0]      lane_res_s;
    logic signed [DATA_WIDTH-1:0] pix_s;
    logic [IW-1:0]                pix_idx_s;
    int                           row_s;
    int                           col_s;
    logic                         tap_vld_s;
    logic                         tap_first_s;
    logic                         last_pos_s;

    for (genvar n = 0; n < NPIX; n++) begin : g_img
        assign img_s[n] = image_i[n*DATA_WIDTH +: DATA_WIDTH];
    end

    for (genvar ch = 0; ch < C; ch++) begin : g_wgt
        for (genvar tt = 0; tt < T; tt++) begin : g_tap
            assign wgt_s[ch][tt] = filter_i[(ch*T+tt)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Pixel fetch for the current tap; taps landing in the padding ring read zero.
    always_comb begin
        row_s     = int'(oy_q) * S + int'(i_q) - P;
        col_s     = int'(ox_q) * S + int'(j_q) - P;
        pix_idx_s = {IW{1'b0}};
        pix_s     = {DATA_WIDTH{1'b0}};
        if ((row_s >= 0) && (row_s < H) && (col_s >= 0) && (col_s < W)) begin
            pix_idx_s = IW'(int'(k_q) * H * W + row_s * W + col_s);
            pix_s     = img_s[pix_idx_s];
        end else begin
            pix_s     = {DATA_WIDTH{1'b0}};
        end
    end

    assign tap_vld_s   = (state_q == ST_RUN);
    assign tap_first_s = (t_q == {TW{1'b0}});
    assign last_pos_s  = (oy_q == YW'(OH - 1)) && (ox_q == XW'(OW - 1));

    for (genvar ch = 0; ch < C; ch++) begin : g_lane
        conv_mac_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .FRAC       (FRAC),
            .ACC_W      (ACC_W)
        ) u_lane (
            .clk         (clk),
            .reset       (reset),
            .pix_i       (pix_s),
            .wgt_i       (wgt_s[ch][t_q]),
            .tap_vld_i   (tap_vld_s),
            .tap_first_i (tap_first_s),
            .res_o       (lane_res_s[ch*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    // Layer FSM, tap/position counters and the output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            t_q         <= {TW{1'b0}};
            k_q         <= {KW{1'b0}};
            i_q         <= {FW{1'b0}};
            j_q         <= {FW{1'b0}};
            oy_q        <= {YW{1'b0}};
            ox_q        <= {XW{1'b0}};
            flush_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= {(C*DATA_WIDTH){1'b0}};
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // done_q still high means the FSM has only just left OUT.
                    if (start_i && !done_q) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                        oy_q    <= {YW{1'b0}};
                        ox_q    <= {XW{1'b0}};
                        t_q     <= {TW{1'b0}};
                        k_q     <= {KW{1'b0}};
                        i_q     <= {FW{1'b0}};
                        j_q     <= {FW{1'b0}};
                    end
                end
                ST_RUN: begin
                    if (t_q == TW'(T - 1)) begin
                        state_q <= ST_FLUSH;
                        flush_q <= 1'b0;
                        t_q     <= {TW{1'b0}};
                        k_q     <= {KW{1'b0}};
                        i_q     <= {FW{1'b0}};
                        j_q     <= {FW{1'b0}};
                    end else begin
                        t_q <= t_q + TW'(1);
                        if (j_q == FW'(F - 1)) begin
                            j_q <= {FW{1'b0}};
                            if (i_q == FW'(F - 1)) begin
                                i_q <= {FW{1'b0}};
                                k_q <= k_q + KW'(1);
                            end else begin
                                i_q <= i_q + FW'(1);
                            end
                        end else begin
                            j_q <= j_q + FW'(1);
                        end
                    end
                end
                ST_FLUSH: begin
                    // Two cycles drain the product and accumulate stages.
                    if (flush_q) begin
                        state_q     <= ST_OUT;
                        out_valid_q <= 1'b1;
                        out_last_q  <= last_pos_s;
                        out_data_q  <= lane_res_s;
                    end else begin
                        flush_q <= 1'b1;
                    end
                end
                ST_OUT: begin
                    if (out_if.out_ready) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        if (out_last_q) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            oy_q    <= {YW{1'b0}};
                            ox_q    <= {XW{1'b0}};
                        end else begin
                            state_q <= ST_RUN;
                            if (ox_q == XW'(OW - 1)) begin
                                ox_q <= {XW{1'b0}};
                                oy_q <= oy_q + YW'(1);
                            end else begin
                                ox_q <= ox_q + XW'(1);
                            end
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign out_if.out_data  = out_data_q;
    assign out_if.out_valid = out_valid_q;
    assign out_if.out_last  = out_last_q;

endmodule

// File: tb/tb_conv_layer_stream.sv
// Directed bench for conv_layer_stream: four instances with different
// parameter sets, all driven from one linear initial block.
module tb_conv_layer_stream;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    // dut1: D=1, 4x4, F=3, C=2, S=1, P=0, DW=32
    logic               start1;
    logic [16*32-1:0]   image1;
    logic [2*9*32-1:0]  filter1;
    logic               busy1, done1;
    conv_layer_stream_if #(.DATA_WIDTH(32), .C(2)) if1 ();
    conv_layer_stream #(.DATA_WIDTH(32), .FRAC(0), .D(1), .H(4), .W(4), .F(3), .C(2), .S(1), .P(0))
        dut1 (.clk(clk), .reset(reset), .start_i(start1), .image_i(image1), .filter_i(filter1),
              .busy_o(busy1), .done_o(done1), .out_if(if1));

    // dut2: same geometry, stride 2, padding 1
    logic               start2;
    logic               busy2, done2;
    conv_layer_stream_if #(.DATA_WIDTH(32), .C(2)) if2 ();
    conv_layer_stream #(.DATA_WIDTH(32), .FRAC(0), .D(1), .H(4), .W(4), .F(3), .C(2), .S(2), .P(1))
        dut2 (.clk(clk), .reset(reset), .start_i(start2), .image_i(image1), .filter_i(filter1),
              .busy_o(busy2), .done_o(done2), .out_if(if2));

    // dut3: depth 2, 2x2 image, F=2, C=1, DW=16, FRAC=2
    logic               start3;
    logic [8*16-1:0]    image3;
    logic [8*16-1:0]    filter3;
    logic               busy3, done3;
    conv_layer_stream_if #(.DATA_WIDTH(16), .C(1)) if3 ();
    conv_layer_stream #(.DATA_WIDTH(16), .FRAC(2), .D(2), .H(2), .W(2), .F(2), .C(1), .S(1), .P(0))
        dut3 (.clk(clk), .reset(reset), .start_i(start3), .image_i(image3), .filter_i(filter3),
              .busy_o(busy3), .done_o(done3), .out_if(if3));

    // dut4: saturation, DW=16
    logic               start4;
    logic [16*16-1:0]   image4;
    logic [2*9*16-1:0]  filter4;
    logic               busy4, done4;
    conv_layer_stream_if #(.DATA_WIDTH(16), .C(2)) if4 ();
    conv_layer_stream #(.DATA_WIDTH(16), .FRAC(0), .D(1), .H(4), .W(4), .F(3), .C(2), .S(1), .P(0))
        dut4 (.clk(clk), .reset(reset), .start_i(start4), .image_i(image4), .filter_i(filter4),
              .busy_o(busy4), .done_o(done4), .out_if(if4));

    int exp1a [4] = '{54, 63, 90, 99};
    int exp1b [4] = '{6, 7, 10, 11};
    int exp2a [4] = '{14, 30, 57, 99};
    int exp2b [4] = '{1, 3, 9, 11};

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp_v);
        checks++;
        assert (obs === exp_v) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic logic sel_valid(input int which);
        case (which)
            2:       return if2.out_valid;
            3:       return if3.out_valid;
            4:       return if4.out_valid;
            default: return if1.out_valid;
        endcase
    endfunction

    // Called on the negedge of a position's first RUN cycle; returns how many
    // negedges later out_valid is seen (200 on timeout).
    task automatic wait_valid(input int which, output int n);
        n = 0;
        while (!sel_valid(which) && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    // One full pass on dut1. stall_beat: beat held with out_ready low for 5
    // cycles (-1 none). poke: pulse start mid-run and in the done cycle.
    task automatic run_pass1(input int stall_beat, input bit poke);
        int n;
        int stray;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check("busy_after_start", busy1, 1);
        for (int b = 0; b < 4; b++) begin
            if (b == stall_beat) if1.out_ready = 1'b0;
            n = 0;
            while (!if1.out_valid && n < 200) begin
                @(negedge clk);
                n++;
                start1 = (poke && b == 0 && n == 3) ? 1'b1 : 1'b0;
            end
            check("valid_latency", n, 11);
            check("beat_ch0", signed'(if1.out_data[31:0]), exp1a[b]);
            check("beat_ch1", signed'(if1.out_data[63:32]), exp1b[b]);
            check("beat_last", if1.out_last, (b == 3));
            if (b == stall_beat) begin
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    check("stall_valid", if1.out_valid, 1);
                    check("stall_ch0", signed'(if1.out_data[31:0]), exp1a[b]);
                    check("stall_ch1", signed'(if1.out_data[63:32]), exp1b[b]);
                    check("stall_last", if1.out_last, 0);
                end
                if1.out_ready = 1'b1;
            end
            @(negedge clk);
            check("valid_drop", if1.out_valid, 0);
            if (b == 3) begin
                check("done_pulse", done1, 1);
                check("busy_clear", busy1, 0);
                if (poke) start1 = 1'b1;
                @(negedge clk);
                start1 = 1'b0;
                check("done_single", done1, 0);
                check("start_in_done_ignored", busy1, 0);
            end else begin
                check("no_early_done", done1, 0);
                check("busy_hold", busy1, 1);
            end
        end
        stray = 0;
        for (int q = 0; q < 14; q++) begin
            @(negedge clk);
            if (if1.out_valid || done1 || busy1) stray++;
        end
        check("idle_quiet", stray, 0);
    endtask

    initial begin
        int n;
        int stray;
        reset  = 1'b1;
        start1 = 1'b0; start2 = 1'b0; start3 = 1'b0; start4 = 1'b0;
        if1.out_ready = 1'b1; if2.out_ready = 1'b1;
        if3.out_ready = 1'b1; if4.out_ready = 1'b1;
        image1 = '0; filter1 = '0; image3 = '0; filter3 = '0;
        image4 = '0; filter4 = '0;
        for (int p = 0; p < 16; p++) image1[p*32 +: 32] = 32'(p + 1);
        for (int t = 0; t < 9; t++) filter1[t*32 +: 32] = 32'd1;
        filter1[(9+4)*32 +: 32] = 32'd1;
        for (int t = 0; t < 18; t++) filter4[t*16 +: 16] = 16'd1;
        image3 = {-16'sd8, -16'sd7, -16'sd6, -16'sd5, 16'sd4, 16'sd3, 16'sd2, 16'sd1};
        filter3 = {16'sd2, 16'sd1, 16'sd1, 16'sd1, 16'sd0, 16'sd0, 16'sd0, 16'sd1};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        check("rst_valid", if1.out_valid, 0);
        check("rst_last", if1.out_last, 0);
        check("rst_data", if1.out_data, 0);
        reset = 1'b0;
        @(negedge clk);

        // Basic pass, stalled pass, start pokes
        run_pass1(-1, 1'b0);
        run_pass1(1, 1'b0);
        run_pass1(-1, 1'b1);

        // Reset during the second position's compute
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        wait_valid(1, n);
        check("pre_reset_latency", n, 11);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_reset_busy", busy1, 0);
        check("mid_reset_valid", if1.out_valid, 0);
        check("mid_reset_done", done1, 0);
        stray = 0;
        for (int q = 0; q < 14; q++) begin
            @(negedge clk);
            if (if1.out_valid || done1) stray++;
        end
        check("post_reset_quiet", stray, 0);
        run_pass1(-1, 1'b0);

        // Stride 2, padding 1
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (int b = 0; b < 4; b++) begin
            wait_valid(2, n);
            check("s2_latency", n, 11);
            check("s2_ch0", signed'(if2.out_data[31:0]), exp2a[b]);
            check("s2_ch1", signed'(if2.out_data[63:32]), exp2b[b]);
            check("s2_last", if2.out_last, (b == 3));
            @(negedge clk);
        end
        check("s2_done", done2, 1);

        // Depth 2 with FRAC=2: -33 >>> 2 rounds toward -inf
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        wait_valid(3, n);
        check("d2_latency", n, 10);
        check("d2_result", signed'(if3.out_data[15:0]), -9);
        check("d2_last", if3.out_last, 1);
        @(negedge clk);
        check("d2_done", done3, 1);

        // Saturation, positive then negative
        for (int pass = 0; pass < 2; pass++) begin
            for (int p = 0; p < 16; p++)
                image4[p*16 +: 16] = (pass == 0) ? 16'sd30000 : -16'sd30000;
            @(negedge clk);
            start4 = 1'b1;
            @(negedge clk);
            start4 = 1'b0;
            for (int b = 0; b < 4; b++) begin
                wait_valid(4, n);
                check("sat_latency", n, 11);
                check("sat_ch0", signed'(if4.out_data[15:0]), (pass == 0) ? 32767 : -32768);
                check("sat_ch1", signed'(if4.out_data[31:16]), (pass == 0) ? 32767 : -32768);
                @(negedge clk);
            end
            check("sat_done", done4, 1);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
